// File: rtl/cmul_arbiter.sv
// rtl/cmul_arbiter.sv - round-robin arbiter sequencing requests onto one complex multiplier
// One operation in flight; a stuck multiplier is bounded by a WAIT-state timeout.
module cmul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       mul_start,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         mul_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [2*WIDTH-1:0]         rsp_result,
    output logic                       rsp_err,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant;
    logic            found;
    logic [ID_W-1:0] id_q;
    logic [15:0]     tcnt;
    logic            timed_out;

    // Rotating search starting at ptr; the sum is one bit wider so the wrap is exact for any NUM_REQ.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign timed_out = (tcnt == 16'(TIMEOUT - 1));
    assign mul_start = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (found) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (mul_done || timed_out) state_nx = S_RESP;
            S_RESP:  if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            id_q       <= '0;
            tcnt       <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mul_a <= req_a[grant*WIDTH +: WIDTH];
                        mul_b <= req_b[grant*WIDTH +: WIDTH];
                        id_q  <= grant;
                        if (grant == ID_W'(NUM_REQ - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= grant + 1'b1;
                        end
                    end
                end
                S_ISSUE: tcnt <= '0;
                S_WAIT: begin
                    // done on the final allowed cycle still counts as success
                    if (mul_done) begin
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                        rsp_id     <= id_q;
                    end else if (timed_out) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_id     <= id_q;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmul_arbiter.sv
// tb/tb_cmul_arbiter.sv - randomized scoreboard bench for cmul_arbiter
// Reference: rotating-priority arbitration and protocol latency modelled with plain arithmetic.
module tb_cmul_arbiter;
    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 8;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_done;
    logic [2*WIDTH-1:0]       mul_result;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_result;
    logic                     rsp_err;
    logic                     busy;

    cmul_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] cmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint ar, ai, br, bi, re, im;
        ar = longint'($signed(a[WIDTH/2-1:0]));
        ai = longint'($signed(a[WIDTH-1:WIDTH/2]));
        br = longint'($signed(b[WIDTH/2-1:0]));
        bi = longint'($signed(b[WIDTH-1:WIDTH/2]));
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {im[WIDTH-1:0], re[WIDTH-1:0]};
    endfunction

    // Multiplier model: combinational, or done pulsed on the done_at-th cycle after start (0 = never).
    bit comb_mode = 1'b1;
    int done_at   = 1;
    int wcnt      = 0;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) wcnt <= 0;
        else if (mul_start) wcnt <= 1;
        else if (wcnt != 0 && wcnt < 1000) wcnt <= wcnt + 1;
    end
    assign mul_done   = comb_mode ? 1'b1 : (done_at != 0 && wcnt == done_at);
    assign mul_result = mul_done ? cmul(mul_a, mul_b) : 64'hDEADBEEF_CAFEF00D;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic [ID_W-1:0]    id;
        logic [2*WIDTH-1:0] res;
        logic               err;
        int                 rsp_cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference model: predicts grants and response contents, pushes to the scoreboard.
    initial begin
        bit              m_idle;
        int              m_ptr;
        int              cur_acc;
        int              g;
        int              wl;
        logic [WIDTH-1:0] cur_a, cur_b;
        exp_t            e;
        m_idle = 1'b1; m_ptr = 0; cur_acc = 0; cur_a = '0; cur_b = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq.delete();
                m_idle = 1'b1;
                m_ptr  = 0;
            end else begin
                chk("busy", 128'(busy), 128'(!m_idle));
                if (!m_idle) begin
                    chk("req_ready_busy", 128'(req_ready), 128'(0));
                    chk("mul_start", 128'(mul_start), 128'(cyc == cur_acc + 1));
                    chk("mul_a_hold", 128'(mul_a), 128'(cur_a));
                    chk("mul_b_hold", 128'(mul_b), 128'(cur_b));
                end else begin
                    g = -1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        int idx;
                        idx = (m_ptr + k) % NUM_REQ;
                        if (g < 0 && req_valid[idx[ID_W-1:0]]) g = idx;
                    end
                    chk("mul_start_idle", 128'(mul_start), 128'(0));
                    if (g < 0) begin
                        chk("req_ready_none", 128'(req_ready), 128'(0));
                    end else begin
                        chk("grant", 128'(req_ready), 128'(1) << g);
                        cur_a = req_a[g*WIDTH +: WIDTH];
                        cur_b = req_b[g*WIDTH +: WIDTH];
                        if (comb_mode) wl = 1;
                        else if (done_at >= 1 && done_at <= TIMEOUT) wl = done_at;
                        else wl = TIMEOUT;
                        e.id      = ID_W'(g);
                        e.err     = !comb_mode && !(done_at >= 1 && done_at <= TIMEOUT);
                        e.res     = e.err ? '0 : cmul(cur_a, cur_b);
                        e.rsp_cyc = cyc + 2 + wl;
                        sbq.push_back(e);
                        cur_acc = cyc;
                        m_ptr   = (g + 1) % NUM_REQ;
                        m_idle  = 1'b0;
                    end
                end
                if (rsp_valid && rsp_ready) m_idle = 1'b1;
            end
        end
    end

    // Monitor: pops on the first cycle of each response, then checks it stays stable.
    initial begin
        bit   have;
        exp_t e;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 1'b0;
            end else if (rsp_valid) begin
                if (!have) begin
                    if (sbq.size() == 0) begin
                        chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
                    end else begin
                        e = sbq.pop_front();
                        have = 1'b1;
                        chk("rsp_cycle", 128'(cyc), 128'(e.rsp_cyc));
                    end
                end
                if (have) begin
                    chk("rsp_id", 128'(rsp_id), 128'(e.id));
                    chk("rsp_result", 128'(rsp_result), 128'(e.res));
                    chk("rsp_err", 128'(rsp_err), 128'(e.err));
                end
                if (rsp_ready) have = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = $urandom();
            req_b[i*WIDTH +: WIDTH] = $urandom();
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            tick();
            if (!busy && sbq.size() == 0) ok = 1'b1;
        end
        chk("drain_timeout", 128'(ok), 128'(1));
    endtask

    task automatic set_mode(input bit c, input int d);
        wait_idle();
        comb_mode = c;
        done_at   = d;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int n = 0; n < 100 && g < 0; n++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
        end
        chk("grant_timeout", 128'(g >= 0), 128'(1));
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        chk({tag, "_mul_start"}, 128'(mul_start), 128'(0));
        chk({tag, "_mul_a"}, 128'(mul_a), 128'(0));
        chk({tag, "_mul_b"}, 128'(mul_b), 128'(0));
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, "_rsp_id"}, 128'(rsp_id), 128'(0));
        chk({tag, "_rsp_result"}, 128'(rsp_result), 128'(0));
        chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        int fair_exp[8];
        bit seen;
        fair_exp = '{0, 1, 2, 3, 0, 1, 3, 1};
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #12;
        check_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Fairness: all active, then only 1 and 3 after the grant to 1
        rand_ops();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            wait_grant(g);
            if (i == 5) req_valid = 4'b1010;
            rand_ops();
            chk("fair_grant", 128'(g), 128'(fair_exp[i]));
        end

        // Single op with known product
        wait_idle();
        req_a[WIDTH-1:0] = 32'h0002_0001;
        req_b[WIDTH-1:0] = 32'h0004_0003;
        req_valid = 4'b0001;
        wait_grant(g);
        req_valid = '0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("single_seen", 128'(seen), 128'(1));
        chk("single_result", 128'(rsp_result), 128'(64'h0000000A_FFFFFFFB));
        chk("single_id", 128'(rsp_id), 128'(0));
        chk("single_err", 128'(rsp_err), 128'(0));

        // Backpressure: hold response while others request
        wait_idle();
        rand_ops();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        wait_grant(g);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("bp_seen", 128'(seen), 128'(1));
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (3) tick();

        // Multi-cycle multiplier, then timeout cases
        set_mode(1'b0, 3);
        rand_ops(); req_valid = 4'b0010; wait_grant(g);
        set_mode(1'b0, 0);
        rand_ops(); req_valid = 4'b0001; wait_grant(g);
        set_mode(1'b0, TIMEOUT);
        rand_ops(); req_valid = 4'b1000; wait_grant(g);
        set_mode(1'b0, TIMEOUT + 1);
        rand_ops(); req_valid = 4'b0100; wait_grant(g);

        // Reset during WAIT for requester 2
        set_mode(1'b0, 0);
        rand_ops(); req_valid = 4'b0100; wait_grant(g);
        req_valid = '0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        tick(); tick();
        rst_n = 1'b1;
        rand_ops();
        req_valid = 4'b1100;
        wait_grant(g);
        chk("post_reset_grant", 128'(g), 128'(2));

        // Randomized traffic
        for (int s = 0; s < 6; s++) begin
            case ($urandom_range(0, 3))
                0: set_mode(1'b1, 1);
                1: set_mode(1'b0, $urandom_range(1, TIMEOUT - 1));
                2: set_mode(1'b0, $urandom_range(TIMEOUT, TIMEOUT + 2));
                default: set_mode(1'b0, 0);
            endcase
            for (int n = 0; n < 60; n++) begin
                req_valid = NUM_REQ'($urandom_range(0, 15));
                rsp_ready = ($urandom_range(0, 3) != 0);
                rand_ops();
                tick();
            end
        end

        wait_idle();
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
